// File: rtl/data_mem_unit.sv
// MEM-stage data RAM: byte/half/word loads and stores behind a valid/ready port with a registered
// 1-cycle response, plus alignment/range/funct3 fault detection and a sequenced post-reset fill.
module data_mem_unit #(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 10,
  parameter int INIT_STEP = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              init_done,
  output logic              dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-2:0] DEPTH_X = (ADDR_W-1)'(DEPTH);
  localparam logic [31:0] STEP = 32'(INIT_STEP);

  // Handshake: a request is taken on any rising edge where req_valid && req_ready; the response
  // is a single-cycle rsp_valid pulse on the following cycle and cannot be stalled.
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              rsp_valid_q, rsp_fault_q;
  logic [31:0]       rsp_rdata_q;
  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  widx;
  logic              accept, fault, store_ok;
  logic [3:0]        be;
  logic [31:0]       wdata_rep, rd_word, load_val, init_val;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  assign req_ready = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);
  assign dbg_state = state_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

  assign word_idx = req_addr[ADDR_W-1:2];
  assign widx     = word_idx[IDX_W-1:0];
  assign accept   = req_valid && req_ready;
  assign store_ok = accept && req_write && !fault;
  assign init_val = 32'(idx_q) * STEP;

  always_comb begin
    fault = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: fault = 1'b0;
      3'b001, 3'b101: fault = req_addr[0];
      3'b010:         fault = (req_addr[1:0] != 2'b00);
      default:        fault = 1'b1;
    endcase
    if ({1'b0, word_idx} >= DEPTH_X) fault = 1'b1;
    if (req_write && req_funct3[2]) fault = 1'b1;
  end

  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    rd_word = mem_q[widx];
    case (req_addr[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_funct3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == IDX_W'(DEPTH - 1)) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
      rsp_valid_q <= accept;
      rsp_fault_q <= accept && fault;
      rsp_rdata_q <= (accept && !fault && !req_write) ? load_val : 32'd0;
    end
  end

  // RAM kept out of the reset block so it maps onto a plain synchronous memory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        mem_q[idx_q] <= init_val;
      end else if (store_ok) begin
        for (int l = 0; l < 4; l++) begin
          if (be[l]) mem_q[widx][8*l +: 8] <= wdata_rep[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed scenarios plus random traffic checked against a byte-array model.
module tb_data_mem_unit;

  localparam int DEPTH     = 256;
  localparam int ADDR_W    = 11;
  localparam int INIT_STEP = 30;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [2:0]        req_funct3 = 3'b010;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic              init_done;
  logic              dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ref_b [DEPTH*4];

  data_mem_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_STEP(INIT_STEP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .init_done(init_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_init();
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = i * INIT_STEP;
      for (int k = 0; k < 4; k++) ref_b[4*i + k] = v[8*k +: 8];
    end
  endfunction

  task automatic drive_random_req();
    req_valid  = 1'($urandom_range(0, 1));
    req_write  = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = ADDR_W'($urandom_range(0, 1023));
    req_wdata  = $urandom;
  endtask

  // One reset cycle followed by the full fill; requests are thrown at the unit throughout.
  task automatic do_reset();
    drive_random_req();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_fault", rsp_fault, 0);
    chk("rst_init_done", init_done, 0);
    reset = 1'b0;
    model_init();
    for (int k = 1; k <= DEPTH; k++) begin
      drive_random_req();
      @(posedge clk); #1;
      chk("init_ready", req_ready, (k == DEPTH) ? 1 : 0);
      chk("init_no_rsp", rsp_valid, 0);
    end
    chk("init_done", init_done, 1);
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input int unsigned a,
                        input logic [31:0] wd);
    int n;
    logic flt;
    logic [31:0] exp_d;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    flt = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (w && f3[2]) ||
          (a % n != 0) || (a / 4 >= DEPTH);
    exp_d = 32'd0;
    if (!flt) begin
      if (w) begin
        for (int i = 0; i < n; i++) ref_b[a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) exp_d[8*i +: 8] = ref_b[a + i];
        if (!f3[2] && n < 4 && exp_d[8*n - 1])
          for (int i = n; i < 4; i++) exp_d[8*i +: 8] = 8'hFF;
      end
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a[ADDR_W-1:0];
    req_wdata  = wd;
    chk("req_ready", req_ready, 1);
    @(posedge clk); #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_fault", rsp_fault, 32'(flt));
    chk("rsp_rdata", rsp_rdata, exp_d);
  endtask

  task automatic do_idle();
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("idle_valid", rsp_valid, 0);
    chk("idle_rdata", rsp_rdata, 0);
    chk("idle_fault", rsp_fault, 0);
  endtask

  initial begin
    int unsigned a;
    logic [2:0] f3;
    logic w;
    int n;

    // Init check
    do_reset();
    do_req(0, 3'b010, 32'h28, 0);  chk("t1_lw28", rsp_rdata, 300);
    do_idle();

    // Byte store / sign extension
    do_req(1, 3'b010, 32'h0, 32'h11223344);
    do_req(1, 3'b000, 32'h1, 32'h000000F0);
    do_req(0, 3'b010, 32'h0, 0);   chk("t2_lw", rsp_rdata, 32'h1122F044);
    do_req(0, 3'b000, 32'h1, 0);   chk("t2_lb", rsp_rdata, 32'hFFFFFFF0);
    do_req(0, 3'b100, 32'h1, 0);   chk("t2_lbu", rsp_rdata, 32'h000000F0);

    // Half store / extension
    do_req(1, 3'b001, 32'h6, 32'h00008001);
    do_req(0, 3'b001, 32'h6, 0);   chk("t3_lh", rsp_rdata, 32'hFFFF8001);
    do_req(0, 3'b101, 32'h6, 0);   chk("t3_lhu", rsp_rdata, 32'h00008001);
    do_req(0, 3'b010, 32'h4, 0);   chk("t3_lw", rsp_rdata, 32'h8001001E);

    // Faults, then memory unchanged
    do_req(0, 3'b010, 32'h2, 0);   chk("t4_lw_mis", rsp_fault, 1);
    do_req(0, 3'b001, 32'h3, 0);   chk("t4_lh_mis", rsp_fault, 1);
    do_req(0, 3'b100, 32'h400, 0); chk("t4_range", rsp_fault, 1);
    do_req(0, 3'b011, 32'h0, 0);   chk("t4_f3", rsp_fault, 1);
    do_req(1, 3'b100, 32'h0, 32'hFFFFFFFF); chk("t4_sbu", rsp_fault, 1);
    do_req(1, 3'b010, 32'h404, 32'hA5A5A5A5); chk("t4_sw_range", rsp_fault, 1);
    do_req(0, 3'b010, 32'h0, 0);   chk("t4_unchanged", rsp_rdata, 32'h1122F044);
    do_idle();

    // Back-to-back store then load
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(0, 3'b010, 32'h10, 0);  chk("t5_raw", rsp_rdata, 32'hDEADBEEF);
    do_idle();

    // Reset mid-operation
    do_req(1, 3'b010, 32'h20, 32'h12345678);
    do_reset();
    do_req(0, 3'b010, 32'h20, 0);  chk("t6_reinit", rsp_rdata, 32'h000000F0);
    do_req(0, 3'b010, 32'h10, 0);  chk("t6_reinit2", rsp_rdata, 32'd120);

    // Random traffic, mostly aligned, with some out-of-range addresses
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_idle();
      end else begin
        w  = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        a  = $urandom_range(0, 1100);
        if ($urandom_range(0, 3) != 0) begin
          a = a % (DEPTH * 4);
          n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
          a = a - (a % n);
        end
        do_req(w, f3, a, $urandom);
      end
    end
    do_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
Parametrised successor to the MEM-stage data memory. Byte-addressed, word-organised synchronous data RAM with a valid/ready request port and a 1-cycle registered response. Supports byte/half/word stores with byte lanes, and sign/zero-extended loads. Adds alignment and range fault detection and a sequenced post-reset initialisation. Sits between the EX stage (address = ALU result, store data = rs2) and writeback.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, 4..4096
ADDR_W, 10, byte-address width; must be >= log2(DEPTH)+2
INIT_STEP, 30, initialisation value of word i is i*INIT_STEP, truncated to 32 bits

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (RISC-V funct3)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data; low bits used for B/H
rsp_valid  out  1  one-cycle pulse; response fields valid
rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and faults
rsp_fault  out  1  request rejected: misaligned, out of range, or illegal funct3
init_done  out  1  high once initialisation is complete

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, init_done=0. Any in-flight response is discarded.
- FSM states: INIT, RUN.
  - Reset forces INIT with the index counter at 0.
  - INIT writes word[idx] = idx*INIT_STEP, one word per cycle. After writing word DEPTH-1 (exactly DEPTH cycles), the FSM moves to RUN.
  - RUN asserts init_done=1 and req_ready=1 continuously.
- Reset mid-INIT or mid-RUN: initialisation restarts from idx 0. Memory contents are overwritten by the sequence.
- Accept: a request is accepted when req_valid && req_ready. Requests presented during INIT are ignored; no response is produced.
- Latency and throughput: the response appears on the cycle after acceptance as a single-cycle rsp_valid pulse. Throughput is one request per cycle. There is no response backpressure.
- Addressing: word index = req_addr[ADDR_W-1:2]; byte lane = req_addr[1:0].
- Fault conditions (no memory write; rsp_rdata=0, rsp_fault=1):
  - H/HU with addr[0] != 0.
  - W with addr[1:0] != 0.
  - Word index >= DEPTH.
  - funct3 of 011, 110 or 111.
  - Store with funct3 BU/HU.
- Stores:
  - SB writes req_wdata[7:0] into lane addr[1:0].
  - SH writes req_wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - Unselected lanes are preserved.
  - The write commits at the accepting clock edge.
  - Response: rsp_valid=1, rsp_rdata=0, rsp_fault=0.
- Loads:
  - The selected byte or half is taken from the word, right-justified.
  - B/H sign-extend; BU/HU zero-extend; W returns the full word.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. Only one access occurs per cycle, so no same-cycle hazard exists.
- Arithmetic: INIT value is idx*INIT_STEP computed in 32 bits, wrap-around permitted.
- Idle: when no request is accepted, rsp_valid=0 and rsp_rdata/rsp_fault return to 0.

Test Plan:
1. Init check: assert reset 1 cycle, release. req_ready=0 for 256 cycles, then init_done=1. LW addr 0x28 -> rsp_rdata=300 (word 10 × 30), rsp_fault=0.
2. Byte store/sign-extend: SW 0x0 <- 0x11223344; SB 0x1 <- 0xF0; LW 0x0 -> 0x1122F044; LB 0x1 -> 0xFFFFFFF0; LBU 0x1 -> 0x000000F0.
3. Half store/extend: SH 0x6 <- 0x8001; LH 0x6 -> 0xFFFF8001; LHU 0x6 -> 0x00008001; LW 0x4 -> 0x80010000 | (old word 1 low half = 30 = 0x001E) = 0x8001001E.
4. Faults: LW 0x2, LH 0x3, LBU 0x400 (word 256), funct3 011, store funct3 100 -> rsp_fault=1, rsp_rdata=0. Subsequent LW 0x0 shows memory unchanged.
5. Back-to-back throughput: SW 0x10 <- 0xDEADBEEF immediately followed by LW 0x10 with req_valid held -> two consecutive rsp_valid pulses; second rsp_rdata=0xDEADBEEF.
6. Reset mid-operation: SW 0x20 <- 0x12345678, then reset for 1 cycle during RUN. After DEPTH cycles, LW 0x20 -> 0x000000F0 (8 × 30). No rsp_valid pulse appears during INIT even with req_valid=1.
